// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the control unit and the
// iterative multiply/divide unit (operands, MTHI/MTLO writes, status, HI/LO).
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    // Control unit side: issues requests and reads HI/LO.
    modport master (
        output start, op, a, b, wr_hi, wr_lo, wr_data,
        input  busy, done, hi, lo
    );

    // Multiply/divide unit side.
    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv.sv
// muldiv: iterative 32x32 multiply / restoring divide unit owning HI/LO.
// A start in IDLE latches operand magnitudes and sign flags; 32 RUN steps
// follow, then a FIX cycle applies sign correction and writes HI/LO.
// Optional divider: build with MULDIV_DIV_EN defined to execute DIV/DIVU;
// without it, ops 10/11 complete as one-cycle no-ops leaving HI/LO intact.
module muldiv (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [4:0]  r_cnt;
    logic [31:0] r_opb;        // multiplicand / divisor magnitude
    logic [63:0] r_acc;        // {upper, lower}: product, or {remainder, quotient}
    logic        r_neg_res;    // negate product / quotient in FIX
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_run_req;
    logic        w_nop;
    logic        w_signed_op;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_nxt;
    logic [63:0] w_prod;

`ifdef MULDIV_DIV_EN
    logic        r_is_div;
    logic        r_neg_rem;    // remainder follows the dividend sign
    logic        r_div0;
    logic [32:0] w_rem_sh;
    logic [32:0] w_rem_diff;
    logic        w_q_bit;
    logic [63:0] w_div_nxt;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
`endif

    // Start is only seen in IDLE, which is exactly when busy is low.
    assign w_accept    = (r_state == S_IDLE) && bus.start;
`ifdef MULDIV_DIV_EN
    assign w_run_req   = w_accept;
    assign w_nop       = 1'b0;
`else
    assign w_run_req   = w_accept && !bus.op[1];
    assign w_nop       = w_accept && bus.op[1];
`endif

    // MULT (00) and DIV (10) are the signed ops.
    assign w_signed_op = !bus.op[0];
    assign w_a_mag     = (w_signed_op && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
    assign w_b_mag     = (w_signed_op && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

    // Shift-add multiply step: lower half starts as the multiplier and is
    // consumed LSB first while the product grows in from the top.
    assign w_mul_sum   = {1'b0, r_acc[63:32]} + {1'b0, r_opb};
    assign w_mul_nxt   = r_acc[0] ? {w_mul_sum, r_acc[31:1]}
                                  : {1'b0, r_acc[63:32], r_acc[31:1]};
    assign w_prod      = r_neg_res ? (~r_acc + 64'd1) : r_acc;

`ifdef MULDIV_DIV_EN
    // Restoring divide step: shift the next dividend bit into the remainder
    // and subtract the divisor when it fits. A zero divisor leaves the full
    // dividend as remainder, so only LO needs forcing for divide-by-zero.
    assign w_rem_sh    = {r_acc[63:32], r_acc[31]};
    assign w_rem_diff  = w_rem_sh - {1'b0, r_opb};
    assign w_q_bit     = !w_rem_diff[32];
    assign w_div_nxt   = {(w_q_bit ? w_rem_diff[31:0] : w_rem_sh[31:0]),
                          r_acc[30:0], w_q_bit};
    assign w_quo       = r_neg_res ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_rem       = r_neg_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so no path through the case leaves the
        // signal unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_run_req) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == 5'd31) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath, HI/LO and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only architectural and status registers are reset; the
            // operand/accumulator registers are always loaded before use.
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_run_req) begin
                        r_busy    <= 1'b1;
                        r_cnt     <= 5'd0;
                        r_opb     <= w_b_mag;
                        r_acc     <= {32'd0, w_a_mag};
                        r_neg_res <= w_signed_op && (bus.a[31] ^ bus.b[31]);
`ifdef MULDIV_DIV_EN
                        r_is_div  <= bus.op[1];
                        r_neg_rem <= w_signed_op && bus.a[31];
                        r_div0    <= (bus.b == 32'd0);
`endif
                    end else if (w_nop) begin
                        r_done <= 1'b1;
                    end else if (!bus.start) begin
                        if (bus.wr_hi) r_hi <= bus.wr_data;
                        if (bus.wr_lo) r_lo <= bus.wr_data;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 5'd1;
`ifdef MULDIV_DIV_EN
                    r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
`else
                    r_acc <= w_mul_nxt;
`endif
                end
                S_FIX: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
`ifdef MULDIV_DIV_EN
                    if (r_is_div) begin
                        r_lo <= r_div0 ? 32'hFFFF_FFFF : w_quo;
                        r_hi <= w_rem;
                    end else begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
`else
                    r_hi <= w_prod[63:32];
                    r_lo <= w_prod[31:0];
`endif
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: directed and randomized checks of muldiv against an arithmetic
// model of HI/LO. Follows MULDIV_DIV_EN to choose divide or no-op behaviour.
module tb_muldiv;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    muldiv_if bus ();

    muldiv u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          e_lat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: updates the modelled HI/LO and the expected latency.
    task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        e_lat = 33;
        case (op)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = sp;
                {m_hi, m_lo} = up;
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = up;
            end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else if (op == 2'b10) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000;
                        m_hi = 32'd0;
                    end else begin
                        sa = $signed(a);
                        sb = $signed(b);
                        m_lo = 32'(sa / sb);
                        m_hi = 32'(sa % sb);
                    end
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
`else
                e_lat = 0;
`endif
            end
        endcase
    endtask

    // Drive a start for one edge; returns one step after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        model_op(op, a, b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for done; check latency, busy width and result.
    task automatic finish_op(input string tag, input int exp_n);
        int n  = 0;
        int bc = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            if (bus.busy === 1'b1) bc++;
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_n));
        check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_n));
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_hi"}, 64'(bus.hi), 64'(m_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(m_lo));
    endtask

    task automatic step_done_low(input string tag);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
    endtask

    task automatic mt(input logic hi_en, input logic lo_en, input logic [31:0] data);
        bus.wr_hi   = hi_en;
        bus.wr_lo   = lo_en;
        bus.wr_data = data;
        @(posedge clk); #1;
        bus.wr_hi   = 1'b0;
        bus.wr_lo   = 1'b0;
        if (hi_en) m_hi = data;
        if (lo_en) m_lo = data;
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        logic [31:0] old_lo;
        int          done_seen;

        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.a       = 32'd0;
        bus.b       = 32'd0;
        bus.wr_hi   = 1'b0;
        bus.wr_lo   = 1'b0;
        bus.wr_data = 32'd0;
        m_hi        = 32'd0;
        m_lo        = 32'd0;
        e_lat       = 33;
        rst         = 1'b1;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed arithmetic cases, with hard constants for the multiplies.
        issue(2'b00, 32'hFFFF_FFFD, 32'd7);
        finish_op("mult_neg", e_lat);
        check("mult_neg_const", {64'(bus.hi), 64'(bus.lo)} >> 0 == 0 ? 64'd0 : {bus.hi, bus.lo},
              64'hFFFF_FFFF_FFFF_FFEB);
        step_done_low("mult_neg");

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("multu_max", e_lat);
        check("multu_max_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        step_done_low("multu_max");

        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_neg", e_lat);
        step_done_low("div_neg");

        issue(2'b11, 32'd7, 32'd0);
        finish_op("divu_zero", e_lat);
        step_done_low("divu_zero");

        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf", e_lat);
        step_done_low("div_ovf");

        issue(2'b10, 32'h8000_0000, 32'd0);
        finish_op("div_zero_neg", e_lat);
        step_done_low("div_zero_neg");

        // New start accepted in the cycle done is high.
        issue(2'b01, 32'd12345, 32'd678);
        finish_op("b2b_first", e_lat);
        issue(2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFFD);
        check("b2b_busy", 64'(bus.busy), 64'd1);
        finish_op("b2b_second", e_lat);
        step_done_low("b2b_second");

        // start and MTHI during busy are both ignored.
        issue(2'b01, 32'd3, 32'd5);
        repeat (4) begin
            @(posedge clk); #1;
        end
        bus.start   = 1'b1;
        bus.op      = 2'b11;
        bus.a       = 32'd100;
        bus.b       = 32'd7;
        bus.wr_hi   = 1'b1;
        bus.wr_data = 32'h0000_AAAA;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.wr_hi   = 1'b0;
        finish_op("busy_ignore", e_lat - 5);
        check("busy_ignore_const", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);

        // MTLO right after done, then simultaneous MTHI/MTLO.
        mt(1'b0, 1'b1, 32'h0000_1234);
        check("mtlo_lo", 64'(bus.lo), 64'h1234);
        check("mtlo_hi_kept", 64'(bus.hi), 64'(m_hi));
        check("mtlo_no_done", 64'(bus.done), 64'd0);
        mt(1'b1, 1'b1, 32'h5A5A_5A5A);
        check("mt_both_hi", 64'(bus.hi), 64'h5A5A_5A5A);
        check("mt_both_lo", 64'(bus.lo), 64'h5A5A_5A5A);

        // MTLO in the same cycle a start is accepted is ignored; LO holds
        // its old value throughout RUN.
        old_lo      = m_lo;
        bus.wr_lo   = 1'b1;
        bus.wr_data = 32'h0000_DEAD;
        issue(2'b01, 32'd2, 32'd3);
        bus.wr_lo   = 1'b0;
        check("accept_mtlo_ignored", 64'(bus.lo), 64'(old_lo));
        check("accept_busy", 64'(bus.busy), 64'd1);
        finish_op("accept_mtlo", e_lat);
        step_done_low("accept_mtlo");

        // Reset mid-operation discards the result.
        issue(2'b00, 32'd6, 32'd7);
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst  = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_hi", 64'(bus.hi), 64'd0);
        check("midrst_lo", 64'(bus.lo), 64'd0);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_seen++;
        end
        check("midrst_no_done", 64'(done_seen), 64'd0);
        check("midrst_hi_after", 64'(bus.hi), 64'd0);

        // Preloaded HI/LO then DIV 10/3 (no-op when the divider is absent).
        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        issue(2'b10, 32'd10, 32'd3);
        finish_op("div_10_3", e_lat);
        step_done_low("div_10_3");

        // Randomized operations, with occasional zero and small divisors.
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            case ($urandom_range(0, 5))
                0:       r_b = 32'd0;
                1:       r_b = 32'($urandom_range(1, 9));
                2:       r_b = 32'hFFFF_FFFF;
                default: r_b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) r_a = 32'h8000_0000;
            issue(r_op, r_a, r_b);
            finish_op($sformatf("rand%0d_op%0d", i, r_op), e_lat);
            step_done_low($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
